// File: rtl/bnn_layer_seq.sv
// ---------------------------------------------------------------------------
// bnn_layer_seq
//   Binary neural network layer. A latched N_IN-bit input vector is scored
//   against N_NEURONS XNOR/popcount/threshold neurons, one neuron per clock,
//   through a single shared datapath. Weights and thresholds are loaded at
//   runtime through a config stream while the block is idle.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   cfg_valid  : config word present
//   cfg_sel    : 0 = weight word, 1 = threshold word
//   cfg_data   : weight (all bits) or threshold (low CNT_W bits)
//   cfg_ready  : config word accepted when cfg_valid & cfg_ready
//   in_valid   : input vector present
//   in_data    : binary input vector
//   in_ready   : idle, input vector can be accepted
//   out_valid  : result held on out_data
//   out_data   : bit i = activation of neuron i
//   out_ready  : downstream accepts result
//   busy       : computing or holding a result
// ---------------------------------------------------------------------------
module bnn_layer_seq #(
    parameter int N_IN      = 6,
    parameter int N_NEURONS = 4,
    parameter int CNT_W     = $clog2(N_IN + 1),
    parameter int THR_RST   = N_IN / 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    input  logic                 cfg_sel,
    input  logic [N_IN-1:0]      cfg_data,
    output logic                 cfg_ready,
    input  logic                 in_valid,
    input  logic [N_IN-1:0]      in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [N_NEURONS-1:0] out_data,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int               IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);
    localparam logic [CNT_W-1:0] THR_INIT = CNT_W'(THR_RST);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [N_IN-1:0]      r_weights [N_NEURONS];
    logic [CNT_W-1:0]     r_thr     [N_NEURONS];
    logic [IDX_W-1:0]     r_wptr;
    logic [IDX_W-1:0]     r_tptr;
    logic [IDX_W-1:0]     r_idx;
    logic [N_IN-1:0]      r_latched;
    logic [N_NEURONS-1:0] r_out_data;

    logic                 w_idle;
    logic                 w_cfg_wr;
    logic                 w_accept;
    logic                 w_last;
    logic [N_IN-1:0]      w_match;
    logic [CNT_W-1:0]     w_pop;
    logic                 w_fire;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_IN-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_IN; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_idle   = (r_state == S_IDLE);
    assign w_cfg_wr = w_idle && cfg_valid;
    assign w_accept = w_idle && in_valid;
    assign w_last   = (r_idx == IDX_LAST);

    // Shared neuron datapath: agreement count between input and weight row.
    assign w_match  = ~(r_latched ^ r_weights[r_idx]);
    assign w_pop    = popcount(w_match);
    assign w_fire   = (w_pop >= r_thr[r_idx]);

    assign out_data = r_out_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        cfg_ready   = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Config storage. Writes only land while idle, so the table is frozen
    // for the whole evaluation of a vector; a write on the accepting edge is
    // already visible to the first neuron evaluated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_weights[i] <= '0;
                r_thr[i]     <= THR_INIT;
            end
            r_wptr <= '0;
            r_tptr <= '0;
        end else if (w_cfg_wr) begin
            if (!cfg_sel) begin
                r_weights[r_wptr] <= cfg_data;
                r_wptr            <= ptr_inc(r_wptr);
            end else begin
                r_thr[r_tptr] <= cfg_data[CNT_W-1:0];
                r_tptr        <= ptr_inc(r_tptr);
            end
        end
    end

    // Evaluation sequencer: one neuron per clock, index wraps back to 0 after
    // the last neuron so it never addresses past the table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_latched  <= '0;
            r_idx      <= '0;
            r_out_data <= '0;
        end else begin
            if (w_accept) begin
                r_latched <= in_data;
                r_idx     <= '0;
            end else if (r_state == S_COMPUTE) begin
                r_out_data[r_idx] <= w_fire;
                r_idx             <= w_last ? '0 : r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bnn_layer_seq.sv
module tb_bnn_layer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: default instance (6 in, 4 neurons); index 1: 9 in, 7 neurons
    logic [1:0] rst;
    logic [1:0] cfg_valid;
    logic [1:0] cfg_sel;
    logic [1:0] in_valid;
    logic [1:0] out_ready;
    logic [5:0] a_cfg_data, a_in_data;
    logic [8:0] b_cfg_data, b_in_data;

    logic       a_cfg_ready, a_in_ready, a_out_valid, a_busy;
    logic       b_cfg_ready, b_in_ready, b_out_valid, b_busy;
    logic [3:0] a_out;
    logic [6:0] b_out;

    int checks = 0;
    int errors = 0;

    bnn_layer_seq dut_a (
        .clk       (clk),
        .reset     (rst[0]),
        .cfg_valid (cfg_valid[0]),
        .cfg_sel   (cfg_sel[0]),
        .cfg_data  (a_cfg_data),
        .cfg_ready (a_cfg_ready),
        .in_valid  (in_valid[0]),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out),
        .out_ready (out_ready[0]),
        .busy      (a_busy)
    );

    bnn_layer_seq #(.N_IN(9), .N_NEURONS(7)) dut_b (
        .clk       (clk),
        .reset     (rst[1]),
        .cfg_valid (cfg_valid[1]),
        .cfg_sel   (cfg_sel[1]),
        .cfg_data  (b_cfg_data),
        .cfg_ready (b_cfg_ready),
        .in_valid  (in_valid[1]),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out),
        .out_ready (out_ready[1]),
        .busy      (b_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: config tables, pointers, and the transaction
    // phase (0 idle, 1 evaluating, 2 holding result).
    // ------------------------------------------------------------------
    int m_w     [2][8];
    int m_t     [2][8];
    int m_wptr  [2];
    int m_tptr  [2];
    int m_phase [2];
    int m_cnt   [2];
    int m_res   [2];

    function automatic int ni(input int d);    return (d != 0) ? 9 : 6;  endfunction
    function automatic int nn(input int d);    return (d != 0) ? 7 : 4;  endfunction
    function automatic int cmask(input int d); return (d != 0) ? 15 : 7; endfunction

    function automatic int compute(input int d, input int x);
        int r;
        int pc;
        r = 0;
        for (int j = 0; j < nn(d); j++) begin
            pc = $countones(~(x ^ m_w[d][j]) & ((1 << ni(d)) - 1));
            if (pc >= m_t[d][j]) r = r | (1 << j);
        end
        return r;
    endfunction

    task automatic model_reset(input int d);
        for (int j = 0; j < 8; j++) begin
            m_w[d][j] = 0;
            m_t[d][j] = ni(d) / 2;
        end
        m_wptr[d]  = 0;
        m_tptr[d]  = 0;
        m_phase[d] = 0;
        m_cnt[d]   = 0;
        m_res[d]   = 0;
    endtask

    task automatic model_step(input int d);
        int cd;
        int id;
        if (rst[d]) return;
        cd = (d != 0) ? int'(b_cfg_data) : int'(a_cfg_data);
        id = (d != 0) ? int'(b_in_data)  : int'(a_in_data);
        case (m_phase[d])
            0: begin
                if (cfg_valid[d]) begin
                    if (!cfg_sel[d]) begin
                        m_w[d][m_wptr[d]] = cd;
                        m_wptr[d] = (m_wptr[d] + 1) % nn(d);
                    end else begin
                        m_t[d][m_tptr[d]] = cd & cmask(d);
                        m_tptr[d] = (m_tptr[d] + 1) % nn(d);
                    end
                end
                if (in_valid[d]) begin
                    m_res[d]   = compute(d, id);
                    m_phase[d] = 1;
                    m_cnt[d]   = 0;
                end
            end
            1: begin
                m_cnt[d]++;
                if (m_cnt[d] == nn(d)) m_phase[d] = 2;
            end
            default: begin
                if (out_ready[d]) m_phase[d] = 0;
            end
        endcase
    endtask

    task automatic check_dut(input int d, input logic cr, input logic ir,
                             input logic ov, input logic bz, input int od);
        chk($sformatf("d%0d_cfg_ready", d), int'(cr), int'(m_phase[d] == 0));
        chk($sformatf("d%0d_in_ready", d),  int'(ir), int'(m_phase[d] == 0));
        chk($sformatf("d%0d_busy", d),      int'(bz), int'(m_phase[d] != 0));
        chk($sformatf("d%0d_out_valid", d), int'(ov), int'(m_phase[d] == 2));
        if (m_phase[d] != 1)
            chk($sformatf("d%0d_out_data", d), od, m_res[d]);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check_dut(0, a_cfg_ready, a_in_ready, a_out_valid, a_busy, int'(a_out));
        check_dut(1, b_cfg_ready, b_in_ready, b_out_valid, b_busy, int'(b_out));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic set_cfg(input int d, input int sel, input int data);
        cfg_valid[d] = 1'b1;
        cfg_sel[d]   = sel[0];
        if (d == 0) a_cfg_data = data[5:0];
        else        b_cfg_data = data[8:0];
    endtask

    task automatic send_cfg(input int d, input int sel, input int data);
        set_cfg(d, sel, data);
        cycle();
        cfg_valid[d] = 1'b0;
    endtask

    task automatic send_vec(input int d, input int x);
        in_valid[d] = 1'b1;
        if (d == 0) a_in_data = x[5:0];
        else        b_in_data = x[8:0];
        cycle();
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, output int n);
        n = 0;
        while (!((d != 0) ? b_out_valid : a_out_valid) && n < 40) begin
            cycle();
            n++;
        end
        if (n >= 40) chk($sformatf("d%0d_valid_timeout", d), 0, 1);
    endtask

    // Accept x, check latency and (when lit >= 0) a hand-computed result,
    // then let the result drain with out_ready high.
    task automatic run_vec(input int d, input int x, input int lit, output int got);
        int n;
        send_vec(d, x);
        wait_valid(d, n);
        chk($sformatf("d%0d_latency", d), n, nn(d));
        got = (d != 0) ? int'(b_out) : int'(a_out);
        if (lit >= 0) begin
            chk($sformatf("d%0d_lit_dut", d), got, lit);
            chk($sformatf("d%0d_lit_model", d), m_res[d], lit);
        end
        cycle();
    endtask

    task automatic pulse_reset(input int d);
        #1;
        rst[d] = 1'b1;
        model_reset(d);
        #1;
        chk($sformatf("d%0d_rst_out_valid", d), int'((d != 0) ? b_out_valid : a_out_valid), 0);
        chk($sformatf("d%0d_rst_busy", d), int'((d != 0) ? b_busy : a_busy), 0);
        cycle();
        cycle();
        rst[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int first;
        int r;
        int n;

        rst        = 2'b11;
        cfg_valid  = 2'b00;
        cfg_sel    = 2'b00;
        in_valid   = 2'b00;
        out_ready  = 2'b11;
        a_cfg_data = '0;
        a_in_data  = '0;
        b_cfg_data = '0;
        b_in_data  = '0;
        model_reset(0);
        model_reset(1);

        cycle();
        chk("rst_a_busy",      int'(a_busy), 0);
        chk("rst_a_out_valid", int'(a_out_valid), 0);
        chk("rst_a_out_data",  int'(a_out), 0);
        chk("rst_a_in_ready",  int'(a_in_ready), 1);
        cycle();
        rst = 2'b00;
        cycle();

        // Defaults: weights 0, thresholds 3
        run_vec(0, 6'b000000, 4'b1111, got);
        run_vec(0, 6'b111111, 4'b0000, got);

        // Loaded weights and thresholds
        send_cfg(0, 0, 6'b111000);
        send_cfg(0, 0, 6'b000111);
        send_cfg(0, 0, 6'b001100);
        send_cfg(0, 0, 6'b110011);
        for (int i = 0; i < 4; i++) send_cfg(0, 1, 2);
        run_vec(0, 6'b111000, 4'b1101, got);

        send_cfg(0, 1, 2);
        send_cfg(0, 1, 2);
        send_cfg(0, 1, 4);
        send_cfg(0, 1, 4);
        run_vec(0, 6'b111000, 4'b0001, got);

        // Threshold 0 on neuron 1
        send_cfg(0, 1, 2);
        send_cfg(0, 1, 0);
        send_cfg(0, 1, 4);
        send_cfg(0, 1, 4);
        run_vec(0, 6'b111000, 4'b0011, got);
        for (int i = 0; i < 4; i++) begin
            run_vec(0, int'($urandom_range(0, 63)), -1, got);
            chk("a_thr0_bit1", (got >> 1) & 1, 1);
        end

        // Config write on the accepting edge is visible to the computation
        set_cfg(0, 0, 6'b000111);
        run_vec(0, 6'b111000, 4'b0010, got);
        send_cfg(0, 0, 6'b000111);
        send_cfg(0, 0, 6'b001100);
        send_cfg(0, 0, 6'b110011);
        set_cfg(0, 0, 6'b111000);
        cycle();
        cfg_valid[0] = 1'b0;

        // Backpressure in DONE with config attempts ignored
        out_ready[0] = 1'b0;
        send_vec(0, 6'b000111);
        wait_valid(0, n);
        chk("a_bp_latency", n, 4);
        first = int'(a_out);
        chk("a_bp_first", first, 4'b0010);
        for (int i = 0; i < 10; i++) begin
            set_cfg(0, 0, 6'b000111);
            cycle();
            chk("a_bp_valid_hold", int'(a_out_valid), 1);
            chk("a_bp_data_hold", int'(a_out), first);
            chk("a_bp_in_ready", int'(a_in_ready), 0);
        end
        cfg_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        cycle();
        chk("a_bp_release_valid", int'(a_out_valid), 0);
        chk("a_bp_release_ready", int'(a_in_ready), 1);
        run_vec(0, 6'b111000, 4'b0011, got);

        // Reset while evaluating neuron 2
        send_vec(0, 6'b111000);
        cycle();
        cycle();
        pulse_reset(0);
        cycle();
        run_vec(0, 6'b000000, 4'b1111, got);
        run_vec(0, 6'b111100, 4'b0000, got);
        run_vec(0, 6'b110000, 4'b1111, got);

        // 9-input, 7-neuron instance: threshold above N_IN never fires,
        // threshold equal to N_IN fires only on a full match.
        r = int'($urandom_range(0, 511));
        send_cfg(1, 0, r);
        send_cfg(1, 0, r);
        for (int i = 2; i < 7; i++) send_cfg(1, 0, int'($urandom_range(0, 511)));
        send_cfg(1, 1, 10);
        send_cfg(1, 1, 9);
        for (int i = 2; i < 7; i++) send_cfg(1, 1, int'($urandom_range(0, 15)));
        run_vec(1, r, -1, got);
        chk("b_thr10_full_match", got & 1, 0);
        chk("b_thr9_full_match", (got >> 1) & 1, 1);
        for (int i = 0; i < 5; i++) begin
            run_vec(1, int'($urandom_range(0, 511)), -1, got);
            chk("b_thr10_never", got & 1, 0);
        end

        // Randomized traffic with backpressure and config during busy
        for (int it = 0; it < 25; it++) begin
            n = int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++)
                send_cfg(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 511)));
            send_vec(1, int'($urandom_range(0, 511)));
            n = 0;
            while (m_phase[1] != 0 && n < 200) begin
                cfg_valid[1] = 1'($urandom_range(0, 1));
                cfg_sel[1]   = 1'($urandom_range(0, 1));
                b_cfg_data   = 9'($urandom_range(0, 511));
                out_ready[1] = 1'($urandom_range(0, 1));
                cycle();
                n++;
            end
            cfg_valid[1] = 1'b0;
            out_ready[1] = 1'b1;
            if (n >= 200) chk("b_rand_timeout", 0, 1);
        end
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
